// File: rtl/fifo_to_sdram_frame_writer_pkg.sv
// fifo_to_sdram_frame_writer_pkg: state encoding, SDRAM address field layout and default frame geometry.
// Shared by the SDRAM frame writer and the SDRAM-to-VGA reader so both agree on the address map.
package fifo_to_sdram_frame_writer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GET_HI,
        GET_LO,
        WRITE,
        DONE
    } wr_state_e;

    localparam int FRAME_ID_W   = 6;
    localparam int LINE_W       = 10;
    localparam int WORD_W       = 9;
    localparam int LINE_LSB     = WORD_W;
    localparam int FRAME_ID_LSB = LINE_LSB + LINE_W;
    localparam int ADDR_W       = FRAME_ID_LSB + FRAME_ID_W;

    localparam int DEF_LINES_PER_FRAME = 768;
    localparam int DEF_WORDS_PER_LINE  = 512;

endpackage

// File: rtl/fifo_to_sdram_frame_writer.sv
// fifo_to_sdram_frame_writer: packs show-ahead FIFO byte pairs into 16-bit Avalon-MM writes for one frame.
// SDRAM_WR_CHECKSUM_EN adds oCHECKSUM, the mod-2^16 sum of every word written in the frame.
module fifo_to_sdram_frame_writer
    import fifo_to_sdram_frame_writer_pkg::*;
#(
    parameter int LINES_PER_FRAME = DEF_LINES_PER_FRAME,
    parameter int WORDS_PER_LINE  = DEF_WORDS_PER_LINE
) (
    input  logic                  iCLK,
    input  logic                  iRST_N,
    input  logic                  iSTART,
    input  logic [FRAME_ID_W-1:0] iFRAME_ID,
    output logic                  oBUSY,
    output logic                  oDONE,
    input  logic                  iFIFO_EMPTY,
    input  logic [7:0]            iFIFO_RDATA,
    output logic                  oFIFO_RDREQ,
    input  logic                  iWAIT_REQUEST,
    output logic                  oWR_EN,
    output logic [ADDR_W-1:0]     oWR_ADDR,
    output logic [15:0]           oWR_DATA
`ifdef SDRAM_WR_CHECKSUM_EN
    ,
    output logic [15:0]           oCHECKSUM
`endif
);

    wr_state_e             state_q, state_d;
    logic [FRAME_ID_W-1:0] frame_q, frame_d;
    logic [LINE_W-1:0]     line_q, line_d;
    logic [WORD_W-1:0]     word_q, word_d;
    logic [15:0]           data_q, data_d;
    logic                  start_ok, accept, last_word, last_frame;

    assign start_ok    = state_q == IDLE && iSTART;
    assign accept      = state_q == WRITE && !iWAIT_REQUEST;
    assign last_word   = word_q == WORD_W'(WORDS_PER_LINE - 1);
    assign last_frame  = last_word && line_q == LINE_W'(LINES_PER_FRAME - 1);

    assign oBUSY       = state_q != IDLE;
    assign oDONE       = state_q == DONE;
    assign oWR_EN      = state_q == WRITE;
    assign oFIFO_RDREQ = (state_q == GET_HI || state_q == GET_LO) && !iFIFO_EMPTY;
    assign oWR_ADDR    = {frame_q, line_q, word_q};
    assign oWR_DATA    = data_q;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= IDLE;
            frame_q <= '0;
            line_q  <= '0;
            word_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            line_q  <= line_d;
            word_q  <= word_d;
            data_q  <= data_d;
        end
    end

    // Address and data registers only move outside a pending write, which keeps the Avalon hold rule.
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        line_d  = line_q;
        word_d  = word_q;
        data_d  = data_q;
        case (state_q)
            IDLE: if (start_ok) begin
                state_d = GET_HI;
                frame_d = iFRAME_ID;
                line_d  = '0;
                word_d  = '0;
            end
            GET_HI: if (oFIFO_RDREQ) begin
                state_d      = GET_LO;
                data_d[15:8] = iFIFO_RDATA;
            end
            GET_LO: if (oFIFO_RDREQ) begin
                state_d     = WRITE;
                data_d[7:0] = iFIFO_RDATA;
            end
            WRITE: if (accept) begin
                state_d = last_frame ? DONE : GET_HI;
                word_d  = last_word ? '0 : word_q + WORD_W'(1);
                line_d  = last_word ? line_q + LINE_W'(1) : line_q;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef SDRAM_WR_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;

    assign sum_d     = start_ok ? '0 : accept ? sum_q + data_q : sum_q;
    assign oCHECKSUM = sum_q;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) sum_q <= '0;
        else         sum_q <= sum_d;
    end
`endif

endmodule

// File: tb/tb_fifo_to_sdram_frame_writer.sv
// tb_fifo_to_sdram_frame_writer: table of frame scenarios on a 2x4 frame, checked against a byte-queue scoreboard.
// Defining SDRAM_WR_CHECKSUM_EN also checks oCHECKSUM.
module tb_fifo_to_sdram_frame_writer;
    localparam int L = 2, W = 4, N = L * W;

    typedef struct {
        logic [5:0] fid;
        bit         seq;
        int         stall_pct;
        int         empty_pct;
        int         stall_word;
        int         gap;
        bit         mid_start;
        int         abort_after;
        int         exp_writes;
    } vec_t;

    logic        clk = 0, rst_n = 1, start = 0, fifo_empty = 1, wait_req = 0;
    logic [5:0]  fid = '0;
    logic [7:0]  rdata = '0;
    logic        busy, done, rdreq, wr_en;
    logic [24:0] addr;
    logic [15:0] wdata;
`ifdef SDRAM_WR_CHECKSUM_EN
    logic [15:0] csum;
`endif
    int          vecs = 0, errs = 0;
    logic [7:0]  q[$];

    always #5 clk = ~clk;

    fifo_to_sdram_frame_writer #(.LINES_PER_FRAME(L), .WORDS_PER_LINE(W)) dut (
        .iCLK(clk), .iRST_N(rst_n), .iSTART(start), .iFRAME_ID(fid),
        .oBUSY(busy), .oDONE(done), .iFIFO_EMPTY(fifo_empty), .iFIFO_RDATA(rdata),
        .oFIFO_RDREQ(rdreq), .iWAIT_REQUEST(wait_req), .oWR_EN(wr_en),
        .oWR_ADDR(addr), .oWR_DATA(wdata)
`ifdef SDRAM_WR_CHECKSUM_EN
        , .oCHECKSUM(csum)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rdreq"}, rdreq, 0);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_addr"}, addr, 0);
        chk({tag, "_data"}, wdata, 0);
`ifdef SDRAM_WR_CHECKSUM_EN
        chk({tag, "_csum"}, csum, 0);
`endif
    endtask

    task automatic cyc(input bit st, input logic [5:0] f, input bit emp, input bit stl);
        @(negedge clk);
        start      = st;
        fid        = f;
        wait_req   = stl;
        fifo_empty = emp || q.size() == 0;
        rdata      = q.size() != 0 ? q[0] : 8'h00;
        #1;
    endtask

    task automatic run_frame(input vec_t v);
        logic [7:0]  b[2*N];
        logic [15:0] sum = '0, pd = '0, ed;
        logic [24:0] pa = '0, ea;
        int          k = 0, pops = 0, n = 0, acc_at = -10, gap_left = 0, stall_used = 0;
        bit          pend = 0, fin = 0;
        for (int i = 0; i < 2 * N; i++) begin
            b[i] = v.seq ? 8'(i + 1) : 8'($urandom);
            q.push_back(b[i]);
        end
        cyc(1, v.fid, 0, 0);
        chk("busy_before_accept", busy, 0);
        while (!fin && n < 2000) begin
            bit gapf = gap_left > 0;
            bit e    = gapf || int'($urandom_range(99)) < v.empty_pct;
            bit s    = (k == v.stall_word && stall_used < 5) || int'($urandom_range(99)) < v.stall_pct;
            bit st   = v.mid_start && $urandom_range(3) == 0;
            cyc(st, ~v.fid, e, s);
            n++;
            if (gap_left > 0) gap_left--;
            if (n == 1) chk("first_rdreq", rdreq, !fifo_empty);
            chk("rdreq_while_empty", rdreq & fifo_empty, 0);
            chk("rdreq_during_write", rdreq & wr_en, 0);
            chk("busy", busy, 1);
            if (gapf) chk("gap_no_write", wr_en, 0);
            if (pend) begin
                chk("hold_en", wr_en, 1);
                chk("hold_addr", addr, pa);
                chk("hold_data", wdata, pd);
            end
            if (wr_en) begin
                if (k >= N) chk("extra_write", k, N - 1);
                else begin
                    ea = {v.fid, 10'(k / W), 9'(k % W)};
                    ed = {b[2*k], b[2*k+1]};
                    chk("wr_addr", addr, ea);
                    chk("wr_data", wdata, ed);
                    if (wait_req && k == v.stall_word) stall_used++;
                    if (!wait_req) begin
                        if (v.seq && k == 0) begin chk("gold0_addr", addr, 25'h0280000); chk("gold0_data", wdata, 16'h0102); end
                        if (v.seq && k == 4) begin chk("gold4_addr", addr, 25'h0280200); chk("gold4_data", wdata, 16'h090A); end
                        if (v.seq && k == 7) begin chk("gold7_addr", addr, 25'h0280203); chk("gold7_data", wdata, 16'h0F10); end
                        sum += ed;
                        k++;
                        acc_at = n;
                    end
                end
            end
            pend = wr_en && wait_req;
            pa   = addr;
            pd   = wdata;
            if (done) begin
                chk("done_latency", n - acc_at, 1);
                chk("writes", k, v.exp_writes);
                chk("pops", pops, 2 * N);
`ifdef SDRAM_WR_CHECKSUM_EN
                chk("checksum", csum, sum);
                if (v.seq) chk("checksum_gold", csum, 16'h4048);
`endif
                fin = 1;
            end
            if (rdreq && !fifo_empty) begin
                pops++;
                void'(q.pop_front());
                if (pops == 1) gap_left = v.gap;
            end
            if (v.abort_after != 0 && k == v.abort_after) begin
                @(posedge clk);
                #2;
                rst_n = 0;
                #1;
                chk_idle_outputs("abort");
                chk("writes", k, v.exp_writes);
                q.delete();
                start    = 0;
                wait_req = 0;
                @(negedge clk);
                rst_n = 1;
                return;
            end
        end
        chk("frame_complete", fin, 1);
        cyc(0, v.fid, 0, 0);
        chk("post_done_busy", busy, 0);
        chk("post_done_pulse", done, 0);
        chk("fifo_leftover", q.size(), 0);
        q.delete();
    endtask

    initial begin
        vec_t tv[10];
        tv[0] = '{6'h05, 1, 0, 0, -1, 0, 0, 0, N};
        tv[1] = '{6'h05, 1, 0, 0, 2, 0, 0, 0, N};
        tv[2] = '{6'h2A, 0, 0, 0, -1, 4, 0, 0, N};
        tv[3] = '{6'h11, 0, 20, 20, -1, 0, 1, 0, N};
        tv[4] = '{6'h3F, 0, 0, 0, -1, 0, 0, 3, 3};
        tv[5] = '{6'h00, 0, 0, 0, -1, 0, 0, 0, N};
        tv[6] = '{6'h1B, 0, 30, 30, -1, 2, 1, 0, N};
        tv[7] = '{6'h24, 0, 50, 10, -1, 0, 0, 0, N};
        tv[8] = '{6'h09, 0, 10, 50, -1, 0, 1, 0, N};
        tv[9] = '{6'h3E, 0, 0, 0, -1, 0, 0, 0, N};
        #1 rst_n = 0;
        #1 chk_idle_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 10; i++) run_frame(tv[i]);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
